// File: rtl/seq_tx_pkg.sv
// ============================================================================
// Module : seq_tx_pkg
// Brief  : Shared state encodings and preamble defaults for the seq TX/RX path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_tx_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_PAR  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_PRE  = ST_PRE,
        S_DATA = ST_DATA,
        S_PAR  = ST_PAR,
        S_GAP  = ST_GAP
    } tx_state_e;

    // The detector side locks onto these same values.
    localparam int         DEF_PRE_LEN  = 3;
    localparam logic [7:0] DEF_PREAMBLE = 8'b0000_0110;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_tx_shifter.sv
// ============================================================================
// Module : seq_tx_shifter
// Brief  : WIDTH-bit parallel-in / serial-out register, MSB first, with the
//          even parity of the loaded word held alongside.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_tx_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             msb_o,
    output logic             parity_o
);

    logic [WIDTH-1:0] shreg_q;
    logic             par_q;

    // Parity is captured at load because shifting destroys the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            par_q   <= 1'b0;
        end else if (load_i) begin
            shreg_q <= din_i;
            par_q   <= ^din_i;
        end else if (shift_i) begin
            shreg_q <= shreg_q << 1;
        end
    end

    assign msb_o    = shreg_q[WIDTH-1];
    assign parity_o = par_q;

endmodule

`default_nettype wire

// File: rtl/seq_pattern_tx.sv
// ============================================================================
// Module : seq_pattern_tx
// Brief  : Serialises a handshaked word as preamble + MSB-first payload
//          [+ parity] + zero gap. Optional parity: define SEQ_TX_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         PRE_LEN  = DEF_PRE_LEN,
    parameter logic [7:0] PREAMBLE = DEF_PREAMBLE,
    parameter int         GAP      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_bit,
    output logic             busy,
    output logic             done
);

    localparam int MAX_LEN = max3(PRE_LEN, WIDTH, GAP);
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             w_load, w_shift;
    logic             w_msb, w_parity;
    logic [7:0]       w_pre_next;

    seq_tx_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_load),
        .shift_i  (w_shift),
        .din_i    (in_data),
        .msb_o    (w_msb),
        .parity_o (w_parity)
    );

    // cnt_q indexes the bit on the line now; the register captures the next one.
    assign w_pre_next = PREAMBLE >> (cnt_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = 1'b0;
        done_d  = 1'b0;
        w_load  = 1'b0;
        w_shift = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_load  = 1'b1;
                    state_d = S_PRE;
                    cnt_d   = PRE_LAST;
                    tx_d    = PREAMBLE[PRE_LEN-1];
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = DATA_LAST;
                    tx_d    = w_msb;
                    w_shift = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    tx_d  = w_pre_next[0];
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - 1'b1;
                    tx_d    = w_msb;
                    w_shift = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = S_PAR;
                    tx_d    = w_parity;
`else
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LAST;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            S_PAR: begin
`ifdef SEQ_TX_PARITY_EN
                if (GAP > 0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LAST;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx_bit   = tx_q;
    assign done     = done_q;

`ifndef SEQ_TX_PARITY_EN
    logic w_unused;
    assign w_unused = w_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
// Module : tb_seq_pattern_tx
// Brief  : Self-checking bench for seq_pattern_tx (frame-list reference model
//          feeding a per-cycle expectation queue).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;

    localparam int         WIDTH    = 8;
    localparam int         PRE_LEN  = 3;
    localparam logic [7:0] PREAMBLE = 8'b0000_0110;
    localparam int         GAP      = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             tx_bit;
    logic             busy;
    logic             done;

    seq_pattern_tx #(
        .WIDTH    (WIDTH),
        .PRE_LEN  (PRE_LEN),
        .PREAMBLE (PREAMBLE),
        .GAP      (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_bit   (tx_bit),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic tx;
        logic rdy;
        logic bsy;
        logic dn;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a flat list of line bits, one per cycle.
    logic m_rem[$];
    logic m_busy, m_cur, m_done;

    task automatic build_frame(input logic [WIDTH-1:0] d);
        logic [7:0] pre_v;
        pre_v = PREAMBLE;
        m_rem.delete();
        for (int i = PRE_LEN - 1; i >= 0; i--) m_rem.push_back(pre_v[i]);
        for (int i = WIDTH - 1; i >= 0; i--) m_rem.push_back(d[i]);
`ifdef SEQ_TX_PARITY_EN
        m_rem.push_back(^d);
`endif
        for (int i = 0; i < GAP; i++) m_rem.push_back(1'b0);
    endtask

    initial begin
        m_busy = 1'b0;
        m_cur  = 1'b0;
        m_done = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_rem.delete();
                m_busy = 1'b0;
                m_cur  = 1'b0;
                m_done = 1'b0;
                sb.delete();
            end else if (m_busy) begin
                if (m_rem.size() > 0) begin
                    m_cur  = m_rem.pop_front();
                    m_done = 1'b0;
                end else begin
                    m_busy = 1'b0;
                    m_cur  = 1'b0;
                    m_done = 1'b1;
                end
            end else begin
                m_done = 1'b0;
                if (in_valid) begin
                    build_frame(in_data);
                    m_cur  = m_rem.pop_front();
                    m_busy = 1'b1;
                end else begin
                    m_cur = 1'b0;
                end
            end
            sb.push_back('{tx: m_cur, rdy: !m_busy, bsy: m_busy, dn: m_done});
        end
    end

    // Monitor: the line is presented every cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("tx_bit",   tx_bit,   e.tx);
                chk("in_ready", in_ready, e.rdy);
                chk("busy",     busy,     e.bsy);
                chk("done",     done,     e.dn);
            end
        end
    end

    task automatic step(input logic v, input logic [WIDTH-1:0] d);
        @(posedge clk);
        #2;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_tx_now",    tx_bit,   1'b0);
        chk("rst_busy_now",  busy,     1'b0);
        chk("rst_ready_now", in_ready, 1'b1);
        chk("rst_done_now",  done,     1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;

        idle(10);

        step(1'b1, 8'hA5);
        idle(16);

        step(1'b1, 8'hFF);
        for (int i = 0; i < 20; i++) step(1'b1, 8'h00);
        idle(20);

        step(1'b1, 8'h3C);
        for (int i = 0; i < 12; i++) step(1'($urandom), WIDTH'($urandom));
        idle(6);

        step(1'b1, 8'hA5);
        step(1'b0, 8'h00);
        repeat (6) @(posedge clk);
        pulse_reset();
        idle(3);

        step(1'b1, 8'h81);
        idle(16);
        step(1'b1, 8'h01);
        idle(16);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, WIDTH'($urandom));
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        idle(20);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
